zxesp32_boot_ctrl: RTL and testbench

Sequences the ESP32 Wi-Fi module through reset and boot-strap selection. It drives the chip-enable line and the GPIO0 strap (gpio_out/gpio_enable), then waits for the ESP32 "alive" signal on GPIO1. It gates the UART passthrough while the module is in reset. It sits between the host register interface and the ESP32 pin glue, all in the clk_peripheral domain.

---
 rtl/zxesp32_boot_ctrl_if.sv | 25 ++
 rtl/zxesp32_boot_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_zxesp32_boot_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zxesp32_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : zxesp32_boot_ctrl_if
//  Description : Host boot-command handshake between register block and
//                the ESP32 boot sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface zxesp32_boot_ctrl_if;
    logic cmd_valid;
    logic cmd_ready;
    logic cmd_mode;

    modport master (
        output cmd_valid,
        output cmd_mode,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/zxesp32_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : zxesp32_boot_ctrl
//  Description : ESP32 reset / GPIO0 boot-strap sequencer with alive wait and
//                UART gating. Optional macro ZXESP32_AUTOBOOT_EN starts a
//                run-mode boot automatically after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module zxesp32_boot_ctrl #(
    parameter int RST_CYCLES     = 28000,
    parameter int STRAP_CYCLES   = 28000,
    parameter int TIMEOUT_CYCLES = 28000000
) (
    input  wire logic          clk_peripheral,
    input  wire logic          reset,
    zxesp32_boot_ctrl_if.slave cmd,
    output logic               esp_en,
    output logic               gpio_out,
    output logic               gpio_enable,
    input  wire logic [2:0]    gpio_in,
    output logic               uart_hold,
    output logic               busy,
    output logic               ready,
    output logic               timeout,
    output logic [2:0]         state
);

    localparam int c_max_a      = (RST_CYCLES > STRAP_CYCLES) ? RST_CYCLES : STRAP_CYCLES;
    localparam int c_max_cycles = (c_max_a > TIMEOUT_CYCLES) ? c_max_a : TIMEOUT_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles) + 1;

    localparam logic [c_cnt_w-1:0] c_rst_load     = c_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_strap_load   = c_cnt_w'(STRAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_load = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

`ifdef ZXESP32_AUTOBOOT_EN
    localparam logic c_reset_cmd_ready = 1'b0;
`else
    localparam logic c_reset_cmd_ready = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_STRAP = 3'd2,
        S_WAIT  = 3'd3,
        S_READY = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_mode;
    logic [2:0]         r_meta;
    logic [2:0]         r_sync;
    logic               r_prev1;

    logic w_start;
    logic w_start_mode;
    logic w_cnt_zero;
    logic w_alive_rise;
    logic w_alive_fall;
    logic w_unused_sync;

    // Two-flop synchroniser plus one history flop for edge detection on GPIO1.
    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            r_meta  <= 3'b000;
            r_sync  <= 3'b000;
            r_prev1 <= 1'b0;
        end else begin
            r_meta  <= gpio_in;
            r_sync  <= r_meta;
            r_prev1 <= r_sync[1];
        end
    end

    assign w_alive_rise  = r_sync[1] & ~r_prev1;
    assign w_alive_fall  = ~r_sync[1] & r_prev1;
    assign w_unused_sync = r_sync[0] ^ r_sync[2];
    assign w_cnt_zero    = (r_cnt == '0);

`ifdef ZXESP32_AUTOBOOT_EN
    logic r_autoboot;

    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            r_autoboot <= 1'b1;
        end else begin
            r_autoboot <= 1'b0;
        end
    end

    assign w_start      = r_autoboot | (cmd.cmd_valid & cmd.cmd_ready);
    assign w_start_mode = r_autoboot ? 1'b0 : cmd.cmd_mode;
`else
    assign w_start      = cmd.cmd_valid & cmd.cmd_ready;
    assign w_start_mode = cmd.cmd_mode;
`endif

    // cmd_ready is high exactly in IDLE/READY/FAIL, so it doubles as the
    // "command may be accepted here" qualifier.
    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_mode        <= 1'b0;
            esp_en        <= 1'b0;
            gpio_out      <= 1'b1;
            gpio_enable   <= 1'b0;
            uart_hold     <= 1'b1;
            cmd.cmd_ready <= c_reset_cmd_ready;
            busy          <= 1'b0;
            ready         <= 1'b0;
            timeout       <= 1'b0;
        end else if (w_start) begin
            r_state       <= S_RESET;
            r_cnt         <= c_rst_load;
            r_mode        <= w_start_mode;
            esp_en        <= 1'b0;
            gpio_out      <= ~w_start_mode;
            gpio_enable   <= 1'b1;
            uart_hold     <= 1'b1;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            ready         <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    cmd.cmd_ready <= 1'b1;
                end
                S_RESET: begin
                    if (w_cnt_zero) begin
                        r_state <= S_STRAP;
                        r_cnt   <= c_strap_load;
                        esp_en  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                S_STRAP: begin
                    if (w_cnt_zero) begin
                        gpio_enable <= 1'b0;
                        gpio_out    <= 1'b1;
                        uart_hold   <= 1'b0;
                        if (r_mode) begin
                            r_state       <= S_READY;
                            ready         <= 1'b1;
                            busy          <= 1'b0;
                            cmd.cmd_ready <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_timeout_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                S_WAIT: begin
                    // An alive edge on the final count still counts as success.
                    if (w_alive_rise) begin
                        r_state       <= S_READY;
                        ready         <= 1'b1;
                        busy          <= 1'b0;
                        cmd.cmd_ready <= 1'b1;
                    end else if (w_cnt_zero) begin
                        r_state       <= S_FAIL;
                        timeout       <= 1'b1;
                        busy          <= 1'b0;
                        cmd.cmd_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                S_READY: begin
                    if (!r_mode && w_alive_fall) begin
                        r_state       <= S_WAIT;
                        r_cnt         <= c_timeout_load;
                        ready         <= 1'b0;
                        busy          <= 1'b1;
                        cmd.cmd_ready <= 1'b0;
                    end
                end
                S_FAIL: begin
                    timeout <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_cnt         <= '0;
                    r_mode        <= 1'b0;
                    esp_en        <= 1'b0;
                    gpio_out      <= 1'b1;
                    gpio_enable   <= 1'b0;
                    uart_hold     <= 1'b1;
                    cmd.cmd_ready <= 1'b1;
                    busy          <= 1'b0;
                    ready         <= 1'b0;
                    timeout       <= 1'b0;
                end
            endcase
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_zxesp32_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zxesp32_boot_ctrl
//  Description : Table, directed and random checks of the ESP32 boot
//                sequencer against a phase/elapsed-time reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zxesp32_boot_ctrl;

    localparam int R = 4;
    localparam int S = 3;
    localparam int T = 20;

`ifdef ZXESP32_AUTOBOOT_EN
    localparam bit c_idle_cr = 1'b0;
`else
    localparam bit c_idle_cr = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] gpio_in;
    logic       esp_en, gpio_out, gpio_enable, uart_hold, busy, ready, timeout;
    logic [2:0] state;

    zxesp32_boot_ctrl_if cmd_if ();

    zxesp32_boot_ctrl #(
        .RST_CYCLES     (R),
        .STRAP_CYCLES   (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_peripheral (clk),
        .reset          (rst),
        .cmd            (cmd_if),
        .esp_en         (esp_en),
        .gpio_out       (gpio_out),
        .gpio_enable    (gpio_enable),
        .gpio_in        (gpio_in),
        .uart_hold      (uart_hold),
        .busy           (busy),
        .ready          (ready),
        .timeout        (timeout),
        .state          (state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase number, cycles spent in phase, and a delay line
    // of the GPIO1 pin as sampled on successive edges (h[0] newest).
    int       m_phase   = 0;
    int       m_elapsed = 0;
    bit       m_mode    = 1'b0;
    bit [2:0] m_hist    = 3'b000;
    bit       m_boot    = 1'b0;

    function automatic logic [10:0] pack(logic [2:0] st, bit en, bit go, bit ge,
                                         bit uh, bit cr, bit bz, bit rd, bit to);
        return {st, en, go, ge, uh, cr, bz, rd, to};
    endfunction

    function automatic logic [10:0] model_out();
        case (m_phase)
            1:       return pack(3'd1, 1'b0, ~m_mode, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            2:       return pack(3'd2, 1'b1, ~m_mode, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            3:       return pack(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            4:       return pack(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            5:       return pack(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            default: return pack(3'd0, 1'b0, 1'b1, 1'b0, 1'b1, ~m_boot, 1'b0, 1'b0, 1'b0);
        endcase
    endfunction

    function automatic logic [10:0] dut_out();
        return {state, esp_en, gpio_out, gpio_enable, uart_hold, cmd_if.cmd_ready,
                busy, ready, timeout};
    endfunction

    task automatic model_step(bit r, bit v, bit md, bit pin);
        bit rise, fall, acc;
        if (r) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_mode    = 1'b0;
            m_hist    = 3'b000;
`ifdef ZXESP32_AUTOBOOT_EN
            m_boot    = 1'b1;
`endif
            return;
        end
        rise   = m_hist[1] & ~m_hist[2];
        fall   = ~m_hist[1] & m_hist[2];
        m_hist = {m_hist[1:0], pin};
        acc    = m_boot || (v && (m_phase == 0 || m_phase == 4 || m_phase == 5));
        if (acc) begin
            m_mode    = m_boot ? 1'b0 : md;
            m_boot    = 1'b0;
            m_phase   = 1;
            m_elapsed = 0;
        end else begin
            case (m_phase)
                1: begin
                    m_elapsed++;
                    if (m_elapsed == R) begin m_phase = 2; m_elapsed = 0; end
                end
                2: begin
                    m_elapsed++;
                    if (m_elapsed == S) begin m_phase = m_mode ? 4 : 3; m_elapsed = 0; end
                end
                3: begin
                    if (rise) m_phase = 4;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == T) m_phase = 5;
                    end
                end
                4: if (!m_mode && fall) begin m_phase = 3; m_elapsed = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic chk(string name, logic [10:0] act, logic [10:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(bit r, bit v, bit md, bit pin);
        rst              = r;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_mode  = md;
        gpio_in          = {1'($urandom), pin, 1'($urandom)};
        @(posedge clk);
        model_step(r, v, md, pin);
        #1;
        chk("cycle_vs_model", dut_out(), model_out());
    endtask

    typedef struct {
        bit          r;
        bit          v;
        bit          md;
        bit          pin;
        int          n;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(bit r, bit v, bit md, bit pin, int n, logic [10:0] e);
        vec_t t;
        t = '{r: r, v: v, md: md, pin: pin, n: n, exp: e};
        vecs.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] p_rst_run, p_strap_run, p_wait, p_ready, p_fail;
        bit pin;
        p_rst_run   = pack(3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        p_strap_run = pack(3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        p_wait      = pack(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        p_ready     = pack(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        p_fail      = pack(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // run boot: 4 RESET + 3 STRAP cycles, alive pin raised 5 cycles into WAIT
        add(0, 1, 0, 0, 1,  p_rst_run);
        add(0, 0, 0, 0, 3,  p_rst_run);
        add(0, 0, 0, 0, 1,  p_strap_run);
        add(0, 0, 0, 0, 2,  p_strap_run);
        add(0, 0, 0, 0, 1,  p_wait);
        add(0, 0, 0, 0, 4,  p_wait);
        add(0, 0, 0, 1, 2,  p_wait);
        add(0, 0, 0, 1, 1,  p_ready);
        // bootloader: strap low for 7 cycles, straight to READY, pin ignored
        add(0, 1, 1, 0, 1,  pack(3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(0, 0, 0, 0, 6,  pack(3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(0, 0, 0, 0, 1,  p_ready);
        add(0, 0, 0, 1, 4,  p_ready);
        add(0, 0, 0, 0, 4,  p_ready);
        // timeout after exactly 20 WAIT cycles, cleared by the next command
        add(0, 1, 0, 0, 1,  p_rst_run);
        add(0, 0, 0, 0, 7,  p_wait);
        add(0, 0, 0, 0, 19, p_wait);
        add(0, 0, 0, 0, 1,  p_fail);
        add(0, 1, 0, 0, 1,  p_rst_run);
        // busy rejection, then reset during STRAP
        add(0, 1, 1, 0, 3,  p_rst_run);
        add(0, 1, 1, 0, 2,  p_strap_run);
        add(1, 0, 0, 0, 1,  pack(3'd0, 1'b0, 1'b1, 1'b0, 1'b1, c_idle_cr, 1'b0, 1'b0, 1'b0));

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("reset_state", dut_out(),
            pack(3'd0, 1'b0, 1'b1, 1'b0, 1'b1, c_idle_cr, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++)
                cyc(vecs[i].r, vecs[i].v, vecs[i].md, vecs[i].pin);
            chk($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // first cycle after reset release
        cyc(0, 0, 0, 0);
`ifdef ZXESP32_AUTOBOOT_EN
        chk("autoboot_reset_entry", 11'(state), 11'(3'd1));
`else
        for (int k = 0; k < 49; k++) cyc(0, 0, 0, 0);
        chk("idle_hold_50", 11'({state, esp_en}), 11'({3'd0, 1'b0}));
`endif

        // self-reboot sequence
        for (int k = 0; k < 20 && state != 3'd3; k++) cyc(0, 1, 0, 0);
        chk("reach_wait", 11'(state), 11'(3'd3));
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("alive_not_early", 11'(state), 11'(3'd3));
        cyc(0, 0, 0, 1);
        chk("alive_ready", 11'({state, ready}), 11'({3'd4, 1'b1}));
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("fall_not_early", 11'({state, ready}), 11'({3'd4, 1'b1}));
        cyc(0, 0, 0, 0);
        chk("reboot_wait", 11'({state, ready}), 11'({3'd3, 1'b0}));
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("reboot_ready", 11'({state, ready}), 11'({3'd4, 1'b1}));
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("fall_vs_cmd", 11'(state), 11'(3'd1));

        // randomized traffic against the model
        pin = 1'b0;
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) pin = ~pin;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
                1'($urandom), pin);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
